sram_arbiter: RTL

- Round-robin arbiter that shares one single-port sram instance (1-cycle registered-address read, per-bit write enable) between NUM_REQ requesters.
- Sits directly in front of the sram and presents a valid/ready request channel plus a read-response strobe to each requester.
- Issues at most one sram access per cycle and routes read data back to the requester that issued the read.

---
 rtl/sram_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port sram between NUM_REQ requesters.
// Latency: request grant is combinational; read data returns exactly 1 cycle after the accepting edge.
// Backpressure: ready goes to at most one valid requester per cycle; responses cannot be stalled.
module sram_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0]              req_we_i,
  input  logic [NUM_REQ*$clog2(DEPTH)-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_be_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            sram_req_o,
  output logic                            sram_we_o,
  output logic [$clog2(DEPTH)-1:0]        sram_addr_o,
  output logic [DATA_WIDTH-1:0]           sram_wdata_o,
  output logic [DATA_WIDTH-1:0]           sram_be_o,
  input  logic [DATA_WIDTH-1:0]           sram_rdata_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IW-1:0] rr_ptr_q;
  logic          rsp_pend_q;
  logic [IW-1:0] rsp_id_q;
  logic          gnt_vld;
  logic [IW-1:0] gnt_id;

  // Scan from the priority pointer with wrap-around; first valid requester wins.
  // Reset masks the grant so every output reads zero while rst_i is high.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    sum     = '0;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) begin
        sum = sum - (IW+1)'(NUM_REQ);
      end
      idx = sum[IW-1:0];
      if (!gnt_vld && req_valid_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
    if (rst_i) begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
    end
  end

  // Route the winner's payload to the sram; reads never carry bit enables.
  always_comb begin
    req_ready_o  = '0;
    sram_req_o   = gnt_vld;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_vld && gnt_id == IW'(k)) begin
        req_ready_o[k] = 1'b1;
        sram_we_o      = req_we_i[k];
        sram_addr_o    = req_addr_i[k*AW +: AW];
        sram_wdata_o   = req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        sram_be_o      = req_we_i[k] ? req_be_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
  end

  // Steer the returning read data to the requester that issued it.
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = rsp_pend_q ? sram_rdata_i : '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_valid_o[k] = rsp_pend_q && (rsp_id_q == IW'(k));
    end
  end

  // Advance priority past the winner and remember who owns the read in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      if (gnt_vld) begin
        if (gnt_id == IW'(NUM_REQ - 1)) begin
          rr_ptr_q <= '0;
        end else begin
          rr_ptr_q <= gnt_id + 1'b1;
        end
      end
      rsp_pend_q <= gnt_vld && !sram_we_o;
      if (gnt_vld && !sram_we_o) begin
        rsp_id_q <= gnt_id;
      end
    end
  end

endmodule
